// File: rtl/pma_region_table_pkg.sv
// Shared types and constants for the PMA region table: address width,
// attribute and region records, write-port FSM states and the platform
// default region set loaded at reset.
package pma_region_table_pkg;

  localparam int PADDR_W = 32;

  typedef struct packed {
    logic r;
    logic w;
    logic x;
    logic a;
    logic c;
  } map_attr_t;

  typedef struct packed {
    logic [PADDR_W-1:0] base;
    logic [PADDR_W-1:0] limit;
    map_attr_t          attr;
    logic               en;
  } pma_region_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  localparam int PMA_DEFAULT_NUM = 6;

  localparam map_attr_t ATTR_RX   = '{r: 1'b1, w: 1'b0, x: 1'b1, a: 1'b1, c: 1'b0};
  localparam map_attr_t ATTR_RW   = '{r: 1'b1, w: 1'b1, x: 1'b0, a: 1'b1, c: 1'b0};
  localparam map_attr_t ATTR_RWXC = '{r: 1'b1, w: 1'b1, x: 1'b1, a: 1'b1, c: 1'b1};

  // Limits are exclusive: each entry's limit is the last byte of the region plus one.
  localparam pma_region_t PMA_DEFAULT_REGIONS [PMA_DEFAULT_NUM] = '{
    '{32'h0000_0000, 32'h0002_0000, ATTR_RX,   1'b1},
    '{32'hf000_0000, 32'hf001_0000, ATTR_RW,   1'b1},
    '{32'hf001_0000, 32'hf002_0000, ATTR_RW,   1'b1},
    '{32'hf0c0_0000, 32'hf100_0000, ATTR_RW,   1'b1},
    '{32'h1000_0000, 32'h1000_2000, ATTR_RWXC, 1'b1},
    '{32'h4000_0000, 32'h40f0_0000, ATTR_RWXC, 1'b1}
  };

endpackage

// File: rtl/pma_region_table_if.sv
// Write and lookup bus of the PMA region table.
// master drives requests and consumes responses; slave is the table itself.
// The slot index is $clog2(ENTRIES) bits wide, so non-power-of-two tables see illegal encodings.
interface pma_region_table_if #(
  parameter int ENTRIES = 8,
  parameter int PADDR_W = pma_region_table_pkg::PADDR_W
);
  import pma_region_table_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  logic               wr_valid;
  logic               wr_ready;
  logic [IDX_W-1:0]   wr_idx;
  logic [PADDR_W-1:0] wr_base;
  logic [PADDR_W-1:0] wr_limit;
  map_attr_t          wr_attr;
  logic               wr_en;
  logic               wr_lock;
  logic               wr_resp_valid;
  logic               wr_resp_err;

  logic               lkup_valid;
  logic [PADDR_W-1:0] lkup_pa;
  logic               lkup_resp_valid;
  logic               lkup_hit;
  map_attr_t          lkup_attr;
  logic               lkup_multi;

  modport master (
    output wr_valid, wr_idx, wr_base, wr_limit, wr_attr, wr_en, wr_lock,
    input  wr_ready, wr_resp_valid, wr_resp_err,
    output lkup_valid, lkup_pa,
    input  lkup_resp_valid, lkup_hit, lkup_attr, lkup_multi
  );

  modport slave (
    input  wr_valid, wr_idx, wr_base, wr_limit, wr_attr, wr_en, wr_lock,
    output wr_ready, wr_resp_valid, wr_resp_err,
    input  lkup_valid, lkup_pa,
    output lkup_resp_valid, lkup_hit, lkup_attr, lkup_multi
  );

endinterface

// File: rtl/pma_region_table_match.sv
// Single-slot region compare: enabled and base <= pa < limit, unsigned.
// Latency: combinational.
// Backpressure: none.
module pma_region_match #(
  parameter int PADDR_W = 32
) (
  input  logic               en,
  input  logic [PADDR_W-1:0] base,
  input  logic [PADDR_W-1:0] limit,
  input  logic [PADDR_W-1:0] pa,
  output logic               hit
);

  assign hit = en && (pa >= base) && (pa < limit);

endmodule

// File: rtl/pma_region_table.sv
// Programmable PMA region table; reset loads the platform default regions.
// Latency: lookup 1 cycle registered; write response 1 cycle after acceptance.
// Backpressure: write port accepts one request every 2 cycles; lookups never stall.
// Optional feature: define PMA_TABLE_LOCK_EN for per-slot write locks.
module pma_region_table #(
  parameter int ENTRIES = 8,
  parameter int PADDR_W = pma_region_table_pkg::PADDR_W
) (
  input logic                i_clk,
  input logic                i_reset,
  pma_region_table_if.slave  bus
);
  import pma_region_table_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  wr_state_t          state_q, state_d;
  logic [PADDR_W-1:0] base_q  [ENTRIES];
  logic [PADDR_W-1:0] limit_q [ENTRIES];
  map_attr_t          attr_q  [ENTRIES];
  logic [ENTRIES-1:0] en_q;
  logic [ENTRIES-1:0] hit_vec;
  logic               wr_fire;
  logic               wr_err;
  logic               idx_oob;
  logic               slot_locked;
  logic               single_hit;
  map_attr_t          attr_or;

  assign wr_fire = bus.wr_valid && (state_q == WR_IDLE);
  assign idx_oob = ({1'b0, bus.wr_idx} >= (IDX_W+1)'(ENTRIES));

`ifdef PMA_TABLE_LOCK_EN
  logic [ENTRIES-1:0] lock_q;

  // Lock of the addressed slot; out-of-range indices have no lock and are rejected anyway.
  always_comb begin
    slot_locked = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (bus.wr_idx == IDX_W'(i)) slot_locked = lock_q[i];
    end
  end
`else
  logic unused_wr_lock;
  assign unused_wr_lock = bus.wr_lock;
  assign slot_locked    = 1'b0;
`endif

  // A disable skips the base/limit check; only enabling an empty/inverted range is illegal.
  assign wr_err = idx_oob || (bus.wr_en && (bus.wr_base >= bus.wr_limit)) || slot_locked;

  // Write FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= WR_IDLE;
    else         state_q <= state_d;
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    state_d           = state_q;
    bus.wr_ready      = 1'b0;
    bus.wr_resp_valid = 1'b0;
    case (state_q)
      WR_IDLE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) state_d = WR_RESP;
      end
      WR_RESP: begin
        bus.wr_resp_valid = 1'b1;
        state_d           = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Error flag captured at acceptance, cleared once the response has been shown.
  always_ff @(posedge i_clk) begin
    if (i_reset)                  bus.wr_resp_err <= 1'b0;
    else if (wr_fire)             bus.wr_resp_err <= wr_err;
    else if (state_q == WR_RESP)  bus.wr_resp_err <= 1'b0;
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
    logic slot_wr;
    assign slot_wr = wr_fire && !wr_err && (bus.wr_idx == IDX_W'(gi));

    // Slot storage: reset to the default region (or cleared), then updated by good writes.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        if (gi < PMA_DEFAULT_NUM) begin
          base_q[gi]  <= PADDR_W'(PMA_DEFAULT_REGIONS[gi].base);
          limit_q[gi] <= PADDR_W'(PMA_DEFAULT_REGIONS[gi].limit);
          attr_q[gi]  <= PMA_DEFAULT_REGIONS[gi].attr;
          en_q[gi]    <= PMA_DEFAULT_REGIONS[gi].en;
        end else begin
          base_q[gi]  <= '0;
          limit_q[gi] <= '0;
          attr_q[gi]  <= '0;
          en_q[gi]    <= 1'b0;
        end
      end else if (slot_wr) begin
        base_q[gi]  <= bus.wr_base;
        limit_q[gi] <= bus.wr_limit;
        attr_q[gi]  <= bus.wr_attr;
        en_q[gi]    <= bus.wr_en;
      end
    end

`ifdef PMA_TABLE_LOCK_EN
    // Lock is sticky until reset.
    always_ff @(posedge i_clk) begin
      if (i_reset)                     lock_q[gi] <= 1'b0;
      else if (slot_wr && bus.wr_lock) lock_q[gi] <= 1'b1;
    end
`endif

    pma_region_match #(.PADDR_W(PADDR_W)) u_match (
      .en    (en_q[gi]),
      .base  (base_q[gi]),
      .limit (limit_q[gi]),
      .pa    (bus.lkup_pa),
      .hit   (hit_vec[gi])
    );
  end

  assign single_hit = (hit_vec != '0) && ((hit_vec & (hit_vec - ENTRIES'(1))) == '0);

  // Attribute of the matching slot; only meaningful when exactly one slot hit.
  always_comb begin
    attr_or = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_vec[i]) attr_or = attr_or | attr_q[i];
    end
  end

  // Registered lookup result, computed against the table as it stands in the request cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.lkup_resp_valid <= 1'b0;
      bus.lkup_hit        <= 1'b0;
      bus.lkup_multi      <= 1'b0;
      bus.lkup_attr       <= '0;
    end else begin
      bus.lkup_resp_valid <= bus.lkup_valid;
      bus.lkup_hit        <= bus.lkup_valid && single_hit;
      bus.lkup_multi      <= bus.lkup_valid && (hit_vec != '0) && !single_hit;
      bus.lkup_attr       <= (bus.lkup_valid && single_hit) ? attr_or : '0;
    end
  end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed self-checking bench for pma_region_table (ENTRIES=8 main instance,
// ENTRIES=6 instance for out-of-range index rejection).
module tb_pma_region_table;
  import pma_region_table_pkg::*;

  localparam logic [4:0] A_RX  = 5'b10110;
  localparam logic [4:0] A_RW  = 5'b11010;
  localparam logic [4:0] A_ALL = 5'b11111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pma_region_table_if #(.ENTRIES(8)) bus8 ();
  pma_region_table_if #(.ENTRIES(6)) bus6 ();

  pma_region_table #(.ENTRIES(8)) dut8 (.i_clk(clk), .i_reset(rst), .bus(bus8.slave));
  pma_region_table #(.ENTRIES(6)) dut6 (.i_clk(clk), .i_reset(rst), .bus(bus6.slave));

  task automatic idle_inputs();
    bus8.wr_valid = 0; bus8.wr_idx = '0; bus8.wr_base = '0; bus8.wr_limit = '0;
    bus8.wr_attr = '0; bus8.wr_en = 0; bus8.wr_lock = 0; bus8.lkup_valid = 0; bus8.lkup_pa = '0;
    bus6.wr_valid = 0; bus6.wr_idx = '0; bus6.wr_base = '0; bus6.wr_limit = '0;
    bus6.wr_attr = '0; bus6.wr_en = 0; bus6.wr_lock = 0; bus6.lkup_valid = 0; bus6.lkup_pa = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One lookup on the 8-entry instance; result captured 1 cycle later.
  task automatic lookup8(input logic [31:0] pa, output logic v, output logic hit,
                         output logic multi, output logic [4:0] attr);
    bus8.lkup_valid = 1'b1;
    bus8.lkup_pa    = pa;
    @(posedge clk); #1;
    bus8.lkup_valid = 1'b0;
    v = bus8.lkup_resp_valid; hit = bus8.lkup_hit; multi = bus8.lkup_multi; attr = bus8.lkup_attr;
  endtask

  // One write on the 8-entry instance; returns handshake observations around the response.
  task automatic write8(input logic [2:0] idx, input logic [31:0] base, input logic [31:0] limit,
                        input logic [4:0] attr, input logic en, input logic lock,
                        output logic rdy_pre, output logic rv, output logic rdy_resp,
                        output logic err, output logic rv_after);
    bus8.wr_valid = 1'b1; bus8.wr_idx = idx; bus8.wr_base = base; bus8.wr_limit = limit;
    bus8.wr_attr = map_attr_t'(attr); bus8.wr_en = en; bus8.wr_lock = lock;
    rdy_pre = bus8.wr_ready;
    @(posedge clk); #1;
    bus8.wr_valid = 1'b0;
    rv = bus8.wr_resp_valid; rdy_resp = bus8.wr_ready; err = bus8.wr_resp_err;
    @(posedge clk); #1;
    rv_after = bus8.wr_resp_valid;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus8.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus8.wr_ready); end
    n_checks++; if (bus8.wr_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", bus8.wr_resp_valid); end
    n_checks++; if (bus8.wr_resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b want 0", bus8.wr_resp_err); end
    n_checks++; if (bus8.lkup_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lkup_valid got %b want 0", bus8.lkup_resp_valid); end
    n_checks++; if ({bus8.lkup_hit, bus8.lkup_multi, bus8.lkup_attr} !== 7'b0) begin
      n_fail++; $display("FAIL reset_lkup_out got %b want 0", {bus8.lkup_hit, bus8.lkup_multi, bus8.lkup_attr}); end
    n_checks++; if (bus6.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready6 got %b want 1", bus6.wr_ready); end
  endtask

  task automatic test_default_lookup();
    logic v, h, m; logic [4:0] a;
    lookup8(32'h0001_0000, v, h, m, a);
    n_checks++; if ({v, h, m, a} !== {3'b110, A_RX}) begin n_fail++; $display("FAIL dflt_rom got v%b h%b m%b a%b want v1 h1 m0 a%b", v, h, m, a, A_RX); end
    lookup8(32'h8000_0000, v, h, m, a);
    n_checks++; if ({v, h, m, a} !== {3'b100, 5'b0}) begin n_fail++; $display("FAIL dflt_miss got v%b h%b m%b a%b want v1 h0 m0 a0", v, h, m, a); end
    lookup8(32'h0001_ffff, v, h, m, a);
    n_checks++; if ({h, a} !== {1'b1, A_RX}) begin n_fail++; $display("FAIL dflt_last_byte got h%b a%b want h1 a%b", h, a, A_RX); end
    lookup8(32'h0002_0000, v, h, m, a);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL dflt_limit_excl got h%b want 0", h); end
    lookup8(32'hf0ff_fffc, v, h, m, a);
    n_checks++; if ({h, a} !== {1'b1, A_RW}) begin n_fail++; $display("FAIL dflt_f0c got h%b a%b want h1 a%b", h, a, A_RW); end
    lookup8(32'h4000_1000, v, h, m, a);
    n_checks++; if ({h, a} !== {1'b1, A_ALL}) begin n_fail++; $display("FAIL dflt_ram got h%b a%b want h1 a%b", h, a, A_ALL); end
  endtask

  task automatic test_write_good();
    logic rp, rv, rr, e, ra, v, h, m; logic [4:0] a;
    write8(3'd6, 32'h8000_0000, 32'h8010_0000, A_ALL, 1'b1, 1'b0, rp, rv, rr, e, ra);
    n_checks++; if ({rp, rv, rr, e, ra} !== 5'b11000) begin n_fail++; $display("FAIL wr6_handshake got rdy%b rv%b rdy_resp%b err%b rv_after%b want 1 1 0 0 0", rp, rv, rr, e, ra); end
    lookup8(32'h8000_0040, v, h, m, a);
    n_checks++; if ({h, m, a} !== {2'b10, A_ALL}) begin n_fail++; $display("FAIL wr6_lookup got h%b m%b a%b want h1 m0 a%b", h, m, a, A_ALL); end
    lookup8(32'h8010_0000, v, h, m, a);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL wr6_limit got h%b want 0", h); end
  endtask

  task automatic test_overlap();
    logic rp, rv, rr, e, ra, v, h, m; logic [4:0] a;
    write8(3'd7, 32'h8008_0000, 32'h8009_0000, A_RW, 1'b1, 1'b0, rp, rv, rr, e, ra);
    n_checks++; if ({rv, e} !== 2'b10) begin n_fail++; $display("FAIL wr7 got rv%b err%b want rv1 err0", rv, e); end
    lookup8(32'h8008_0010, v, h, m, a);
    n_checks++; if ({h, m, a} !== {2'b01, 5'b0}) begin n_fail++; $display("FAIL overlap got h%b m%b a%b want h0 m1 a0", h, m, a); end
  endtask

  task automatic test_reject();
    logic rp, rv, rr, e, ra, v, h, m; logic [4:0] a;
    write8(3'd6, 32'h9000_0000, 32'h9000_0000, A_RX, 1'b1, 1'b0, rp, rv, rr, e, ra);
    n_checks++; if ({rv, e} !== 2'b11) begin n_fail++; $display("FAIL rej_empty got rv%b err%b want rv1 err1", rv, e); end
    lookup8(32'h8000_0040, v, h, m, a);
    n_checks++; if ({h, a} !== {1'b1, A_ALL}) begin n_fail++; $display("FAIL rej_unchanged got h%b a%b want h1 a%b", h, a, A_ALL); end
    lookup8(32'h9000_0000, v, h, m, a);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL rej_no_new got h%b want 0", h); end
    // Out-of-range indices 6 and 7 on the 6-entry table, then the last legal index.
    for (int k = 0; k < 3; k++) begin
      bus6.wr_valid = 1'b1; bus6.wr_idx = (k == 2) ? 3'd5 : 3'(6 + k);
      bus6.wr_base = 32'h0000_0000; bus6.wr_limit = 32'h5000_1000;
      bus6.wr_attr = map_attr_t'(A_ALL); bus6.wr_en = 1'b1; bus6.wr_lock = 1'b0;
      @(posedge clk); #1;
      bus6.wr_valid = 1'b0;
      n_checks++; if ({bus6.wr_resp_valid, bus6.wr_resp_err} !== {1'b1, (k != 2)}) begin
        n_fail++; $display("FAIL rej_idx%0d got rv%b err%b want rv1 err%b", bus6.wr_idx, bus6.wr_resp_valid, bus6.wr_resp_err, (k != 2)); end
      @(posedge clk); #1;
    end
    // Slot 0 still alone at 0x10000 would mean 6/7 wrote nothing; slot 5 now overlaps it.
    bus6.lkup_valid = 1'b1; bus6.lkup_pa = 32'h0001_0000;
    @(posedge clk); #1;
    bus6.lkup_valid = 1'b0;
    n_checks++; if ({bus6.lkup_hit, bus6.lkup_multi} !== 2'b01) begin n_fail++; $display("FAIL rej6_table got h%b m%b want h0 m1", bus6.lkup_hit, bus6.lkup_multi); end
    bus6.lkup_valid = 1'b1; bus6.lkup_pa = 32'h4000_0000;
    @(posedge clk); #1;
    bus6.lkup_valid = 1'b0;
    n_checks++; if ({bus6.lkup_hit, bus6.lkup_multi} !== 2'b10) begin n_fail++; $display("FAIL rej6_slot5 got h%b m%b want h1 m0", bus6.lkup_hit, bus6.lkup_multi); end
  endtask

  task automatic test_same_cycle();
    // Disable with base=limit=0: legal since disables skip the range check.
    bus8.wr_valid = 1'b1; bus8.wr_idx = 3'd6; bus8.wr_base = '0; bus8.wr_limit = '0;
    bus8.wr_attr = '0; bus8.wr_en = 1'b0; bus8.wr_lock = 1'b0;
    bus8.lkup_valid = 1'b1; bus8.lkup_pa = 32'h8000_0040;
    @(posedge clk); #1;
    bus8.wr_valid = 1'b0;
    n_checks++; if ({bus8.lkup_hit, bus8.lkup_attr} !== {1'b1, A_ALL}) begin n_fail++; $display("FAIL same_cycle_old got h%b a%b want h1 a%b", bus8.lkup_hit, bus8.lkup_attr, A_ALL); end
    n_checks++; if ({bus8.wr_resp_valid, bus8.wr_resp_err} !== 2'b10) begin n_fail++; $display("FAIL disable_resp got rv%b err%b want rv1 err0", bus8.wr_resp_valid, bus8.wr_resp_err); end
    @(posedge clk); #1;
    bus8.lkup_valid = 1'b0;
    n_checks++; if ({bus8.lkup_resp_valid, bus8.lkup_hit, bus8.lkup_multi, bus8.lkup_attr} !== {3'b100, 5'b0}) begin
      n_fail++; $display("FAIL resp_cycle_new got v%b h%b m%b a%b want v1 h0 m0 a0", bus8.lkup_resp_valid, bus8.lkup_hit, bus8.lkup_multi, bus8.lkup_attr); end
  endtask

  task automatic test_lock();
    logic rp, rv, rr, e, ra, v, h, m; logic [4:0] a;
    write8(3'd6, 32'h8000_0000, 32'h8010_0000, A_ALL, 1'b1, 1'b1, rp, rv, rr, e, ra);
    n_checks++; if ({rv, e} !== 2'b10) begin n_fail++; $display("FAIL lock_set got rv%b err%b want rv1 err0", rv, e); end
    write8(3'd6, 32'h0, 32'h0, 5'b0, 1'b0, 1'b0, rp, rv, rr, e, ra);
`ifdef PMA_TABLE_LOCK_EN
    n_checks++; if ({rv, e} !== 2'b11) begin n_fail++; $display("FAIL lock_rewrite got rv%b err%b want rv1 err1", rv, e); end
    lookup8(32'h8000_0040, v, h, m, a);
    n_checks++; if ({h, a} !== {1'b1, A_ALL}) begin n_fail++; $display("FAIL lock_kept got h%b a%b want h1 a%b", h, a, A_ALL); end
    do_reset();
    lookup8(32'h8000_0040, v, h, m, a);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL lock_reset_dis got h%b want 0", h); end
    write8(3'd6, 32'h0, 32'h0, 5'b0, 1'b0, 1'b0, rp, rv, rr, e, ra);
    n_checks++; if ({rv, e} !== 2'b10) begin n_fail++; $display("FAIL lock_cleared got rv%b err%b want rv1 err0", rv, e); end
`else
    n_checks++; if ({rv, e} !== 2'b10) begin n_fail++; $display("FAIL nolock_rewrite got rv%b err%b want rv1 err0", rv, e); end
    lookup8(32'h8000_0040, v, h, m, a);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL nolock_disabled got h%b want 0", h); end
    do_reset();
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat = '0;
    bus8.wr_valid = 1'b1; bus8.wr_idx = 3'd7; bus8.wr_base = '0; bus8.wr_limit = '0;
    bus8.wr_attr = '0; bus8.wr_en = 1'b0; bus8.wr_lock = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      pat = {pat[2:0], bus8.wr_resp_valid};
    end
    bus8.wr_valid = 1'b0;
    n_checks++; if (pat !== 4'b1010) begin n_fail++; $display("FAIL b2b_pattern got %b want 1010", pat); end
  endtask

  task automatic test_reset_during_resp();
    logic v, h, m; logic [4:0] a; int late = 0;
    bus8.wr_valid = 1'b1; bus8.wr_idx = 3'd6; bus8.wr_base = 32'h8000_0000; bus8.wr_limit = 32'h8010_0000;
    bus8.wr_attr = map_attr_t'(A_ALL); bus8.wr_en = 1'b1; bus8.wr_lock = 1'b0;
    @(posedge clk); #1;
    bus8.wr_valid = 1'b0;
    n_checks++; if (bus8.wr_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rdr_resp got %b want 1", bus8.wr_resp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({bus8.wr_resp_valid, bus8.wr_ready} !== 2'b01) begin n_fail++; $display("FAIL rdr_dropped got rv%b rdy%b want rv0 rdy1", bus8.wr_resp_valid, bus8.wr_ready); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus8.wr_resp_valid) late++;
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL rdr_no_late_resp got %0d want 0", late); end
    lookup8(32'h8000_0040, v, h, m, a);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL rdr_table_reset got h%b want 0", h); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_default_lookup();
    test_write_good();
    test_overlap();
    test_reject();
    test_same_cycle();
    test_lock();
    test_back_to_back();
    test_reset_during_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
